pipelined_left_shifter: RTL

Pipelined logical left barrel shifter with valid/ready handshaking on both sides, the left-shift counterpart of the conditional right-shift stages in the barrel shifter library. It decomposes a shift by ISHAMT into log2(DATA_WIDTH) registered stages, each shifting left by a fixed power of two, and sustains one operation per clock. It sits between an operand source and any ALU/result consumer that may apply backpressure.

---
 rtl/pipelined_left_shifter_pkg.sv | 13 +
 rtl/pipelined_left_shifter_stage.sv | 74 +++++++
 rtl/pipelined_left_shifter.sv | 76 +++++++
 3 files changed

// File: rtl/pipelined_left_shifter_pkg.sv
// Shared constants and helpers for the pipelined left shifter.
// No ports: provides the shift-amount width function and stage count.
package pipelined_left_shifter_pkg;

    localparam int unsigned LSH_DEF_WIDTH = 32;

    function automatic int unsigned shamt_width(input int unsigned width);
        return $clog2(width);
    endfunction

    localparam int unsigned LSH_DEF_STAGES = shamt_width(LSH_DEF_WIDTH);

endpackage

// File: rtl/pipelined_left_shifter_stage.sv
// One pipeline stage of the left shifter: conditional fixed shift by 2^N.
// Ports: clk_i/rst_i, next_load_i (downstream load), in_* from the previous
// stage, load_o (this stage loads), valid_o/data_o/shamt_o registered outputs.
// Build option LSHIFT_ROTATE_EN: rotate instead of zero-fill shift.
module left_shift_stage
    import pipelined_left_shifter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = LSH_DEF_WIDTH,
    parameter int unsigned N          = 0,
    parameter int unsigned SW         = shamt_width(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  next_load_i,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [SW-1:0]         in_shamt_i,
    output logic                  load_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [SW-1:0]         shamt_o
);

    localparam int unsigned DIST = 1 << N;

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [SW-1:0]         shamt_q, shamt_d;
    logic [DATA_WIDTH-1:0] moved;
    logic [DATA_WIDTH-1:0] shifted;

`ifdef LSHIFT_ROTATE_EN
    assign moved = (in_data_i << DIST)
                 | (in_data_i >> (DATA_WIDTH - DIST));
`else
    assign moved = in_data_i << DIST;
`endif

    // Bit 0 of the incoming shamt always belongs to this stage; the
    // remaining bits travel shifted down so the next stage sees its bit at 0.
    assign shifted = in_shamt_i[0] ? moved : in_data_i;

    assign load_o = ~valid_q | next_load_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        if (load_o) begin
            valid_d = in_valid_i;
            data_d  = shifted;
            shamt_d = in_shamt_i >> 1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload is not reset; it is qualified by valid.
    always_ff @(posedge clk_i) begin
        data_q  <= data_d;
        shamt_q <= shamt_d;
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;

endmodule

// File: rtl/pipelined_left_shifter.sv
// Pipelined logical left barrel shifter with valid/ready on both sides.
// Ports: CLK, RST (sync, active high), IVALID/IREADY/IDATA/ISHAMT input side,
// OVALID/OREADY/ODATA output side, BUSY = any stage valid.
// Build option LSHIFT_ROTATE_EN: every stage rotates instead of shifting.
module pipelined_left_shifter
    import pipelined_left_shifter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = LSH_DEF_WIDTH,
    parameter int unsigned SHAMT_WIDTH = shamt_width(DATA_WIDTH)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IVALID,
    output logic                   IREADY,
    input  logic [DATA_WIDTH-1:0]  IDATA,
    input  logic [SHAMT_WIDTH-1:0] ISHAMT,
    output logic                   OVALID,
    input  logic                   OREADY,
    output logic [DATA_WIDTH-1:0]  ODATA,
    output logic                   BUSY
);

    localparam int unsigned SW = SHAMT_WIDTH;

    logic [DATA_WIDTH-1:0] data_c  [SW+1];
    logic [SW-1:0]         shamt_c [SW+1];
    logic [SW-1:0]         valid_s;
    logic [SW:0]           valid_in;
    logic [SW-1:0]         load_s;
    logic [SW-1:0]         next_load;
    logic                  unused_sig;

    assign data_c[0]  = IDATA;
    assign shamt_c[0] = ISHAMT;
    assign valid_in   = {valid_s, IVALID};

    // Downstream load for stage k is stage k+1's load, flattened from the
    // valid bits so the ready chain has no self-referencing net.
    always_comb begin
        logic full;
        full      = 1'b1;
        next_load = '0;
        for (int k = SW - 1; k >= 0; k--) begin
            next_load[k] = OREADY | ~full;
            full         = full & valid_s[k];
        end
    end

    for (genvar k = 0; k < SW; k++) begin : g_stage
        left_shift_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .N          (k),
            .SW         (SW)
        ) u_stage (
            .clk_i       (CLK),
            .rst_i       (RST),
            .next_load_i (next_load[k]),
            .in_valid_i  (valid_in[k]),
            .in_data_i   (data_c[k]),
            .in_shamt_i  (shamt_c[k]),
            .load_o      (load_s[k]),
            .valid_o     (valid_s[k]),
            .data_o      (data_c[k+1]),
            .shamt_o     (shamt_c[k+1])
        );
    end

    // Held high during reset so the source sees a clean ready on release.
    assign IREADY = load_s[0] | RST;
    assign OVALID = valid_s[SW-1];
    assign ODATA  = data_c[SW];
    assign BUSY   = |valid_s;

    assign unused_sig = ^{load_s, shamt_c[SW]};

endmodule
